// File: rtl/seg_scan_decoder.sv
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Decodes a time-multiplexed active-low 8-digit seven-segment bus
//            back into a 32-bit hex frame with dp and error masks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_id,
    input  logic [7:0]  seg_in,
    output logic [31:0] value,
    output logic [7:0]  dp_mask,
    output logic [7:0]  err_mask,
    output logic        frame_valid,
    output logic        locked
);

    typedef enum logic [0:0] {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [7:0] c_stable    = 8'(STABLE_CYC);
    localparam logic [7:0] c_stable_m1 = 8'(STABLE_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_s_q;
    logic [7:0]  r_cnt;
    logic [31:0] r_sh_nib;
    logic [7:0]  r_sh_dp;
    logic [7:0]  r_sh_err;
    logic [7:0]  r_seen;
    logic [31:0] r_value;
    logic [7:0]  r_dp_mask;
    logic [7:0]  r_err_mask;
    logic        r_frame_valid;
    logic        r_locked;

    logic [15:0] w_pair;
    logic        w_same;
    logic        w_strobe;
    logic [7:0]  w_sel;
    logic        w_sel_one;
    logic        w_cap;
    logic [3:0]  w_nib;
    logic        w_err;
    logic        w_dp;
    logic [31:0] w_mask32;
    logic [31:0] w_nib_merged;
    logic [7:0]  w_dp_merged;
    logic [7:0]  w_err_merged;
    logic [7:0]  w_seen_merged;
    logic        w_accept;
    logic        w_done;

    assign w_pair   = {seg_id, seg_in};
    assign w_same   = (w_pair == r_s_q);
    assign w_strobe = w_same && (r_cnt == c_stable_m1);

    // At the strobe the input equals s_q, so decode from the registered copy.
    assign w_sel     = ~r_s_q[15:8];
    assign w_sel_one = (w_sel != 8'd0) && ((w_sel & (w_sel - 8'd1)) == 8'd0);
    assign w_cap     = w_strobe && w_sel_one;
    assign w_dp      = ~r_s_q[0];

    always_comb begin
        w_nib = 4'h0;
        w_err = 1'b0;
        case ({r_s_q[7:1], 1'b1})
            8'h03:   w_nib = 4'h0;
            8'h9F:   w_nib = 4'h1;
            8'h25:   w_nib = 4'h2;
            8'h0D:   w_nib = 4'h3;
            8'h99:   w_nib = 4'h4;
            8'h49:   w_nib = 4'h5;
            8'h41:   w_nib = 4'h6;
            8'h1F:   w_nib = 4'h7;
            8'h01:   w_nib = 4'h8;
            8'h09:   w_nib = 4'h9;
            8'h11:   w_nib = 4'hA;
            8'hC1:   w_nib = 4'hB;
            8'h63:   w_nib = 4'hC;
            8'h85:   w_nib = 4'hD;
            8'h61:   w_nib = 4'hE;
            8'h71:   w_nib = 4'hF;
            default: w_err = 1'b1;
        endcase
    end

    generate
        for (genvar k = 0; k < 8; k++) begin : g_mask
            assign w_mask32[4*k +: 4] = {4{w_sel[k]}};
        end
    endgenerate

    // Shadow contents with the current capture folded in; used both for the
    // shadow update and for publishing a completed frame in the same edge.
    assign w_nib_merged  = (r_sh_nib & ~w_mask32) | ({8{w_nib}} & w_mask32);
    assign w_dp_merged   = (r_sh_dp  & ~w_sel)    | ({8{w_dp}}  & w_sel);
    assign w_err_merged  = (r_sh_err & ~w_sel)    | ({8{w_err}} & w_sel);
    assign w_seen_merged = r_seen | w_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_cap && (w_sel == 8'h01)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (w_cap) begin
                    w_accept = 1'b1;
                    w_done   = (w_seen_merged == 8'hFF);
                end
            end
            default: w_state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_q <= 16'hFFFF;
            r_cnt <= 8'd0;
        end else begin
            r_s_q <= w_pair;
            if (!w_same) begin
                r_cnt <= 8'd0;
            end else if (r_cnt < c_stable) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_nib      <= 32'd0;
            r_sh_dp       <= 8'd0;
            r_sh_err      <= 8'd0;
            r_seen        <= 8'd0;
            r_value       <= 32'd0;
            r_dp_mask     <= 8'd0;
            r_err_mask    <= 8'd0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_frame_valid <= w_done;
            if (w_accept) begin
                r_sh_nib <= w_nib_merged;
                r_sh_dp  <= w_dp_merged;
                r_sh_err <= w_err_merged;
                if (w_done) begin
                    r_seen <= 8'd0;
                end else if (r_state == SYNC) begin
                    r_seen <= 8'h01;
                end else begin
                    r_seen <= w_seen_merged;
                end
            end
            if (w_done) begin
                r_value    <= w_nib_merged;
                r_dp_mask  <= w_dp_merged;
                r_err_mask <= w_err_merged;
                r_locked   <= 1'b1;
            end
        end
    end

    assign value       = r_value;
    assign dp_mask     = r_dp_mask;
    assign err_mask    = r_err_mask;
    assign frame_valid = r_frame_valid;
    assign locked      = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Directed and randomized bench for seg_scan_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  seg_id = 8'hFF;
    logic [7:0]  seg_in = 8'hFF;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic [7:0]  err_mask;
    logic        frame_valid;
    logic        locked;

    seg_scan_decoder #(.STABLE_CYC(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_id      (seg_id),
        .seg_in      (seg_in),
        .value       (value),
        .dp_mask     (dp_mask),
        .err_mask    (err_mask),
        .frame_valid (frame_valid),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] code_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                  8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Reference model: frame assembly as seen from the display, per edge.
    bit          m_collect;
    logic [3:0]  m_nib [8];
    logic [7:0]  m_dp, m_err, m_seen;
    logic [15:0] m_prev;
    int          m_run;
    logic [31:0] e_value;
    logic [7:0]  e_dp, e_err;
    logic        e_fv, e_locked;
    int          obs_pulses = 0;
    int          exp_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_collect = 1'b0;
        m_seen    = 8'd0;
        m_dp      = 8'd0;
        m_err     = 8'd0;
        for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
        m_prev    = 16'hFFFF;
        m_run     = 1;
        e_value   = 32'd0;
        e_dp      = 8'd0;
        e_err     = 8'd0;
        e_fv      = 1'b0;
        e_locked  = 1'b0;
    endtask

    task automatic decode(input logic [7:0] pat, output logic [3:0] nib, output logic err);
        nib = 4'h0;
        err = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pat[7:1] == code_tab[i][7:1]) begin
                nib = 4'(i);
                err = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        logic [15:0] pair;
        logic [7:0]  sel;
        logic [3:0]  nib;
        logic        err;
        int          k;
        pair = {seg_id, seg_in};
        if (pair == m_prev) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_prev = pair;
            m_run  = 1;
        end
        e_fv = 1'b0;
        sel  = ~seg_id;
        if (m_run == S + 1 && $countones(sel) == 1) begin
            k = 0;
            for (int i = 0; i < 8; i++) if (sel[i]) k = i;
            decode(seg_in, nib, err);
            if (m_collect || k == 0) begin
                if (!m_collect) begin
                    m_collect = 1'b1;
                    m_seen    = 8'd0;
                end
                m_nib[k]  = nib;
                m_dp[k]   = ~seg_in[0];
                m_err[k]  = err;
                m_seen[k] = 1'b1;
                if (m_seen == 8'hFF) begin
                    for (int i = 0; i < 8; i++) e_value[4*i +: 4] = m_nib[i];
                    e_dp     = m_dp;
                    e_err    = m_err;
                    e_fv     = 1'b1;
                    e_locked = 1'b1;
                    m_seen   = 8'd0;
                    exp_pulses++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("frame_valid", 32'(frame_valid), 32'(e_fv));
        check("locked",      32'(locked),      32'(e_locked));
        check("value",       value,            e_value);
        check("dp_mask",     32'(dp_mask),     32'(e_dp));
        check("err_mask",    32'(err_mask),    32'(e_err));
        if (frame_valid === 1'b1) obs_pulses++;
    endtask

    task automatic show(input logic [7:0] id, input logic [7:0] pat, input int hold);
        seg_id = id;
        seg_in = pat;
        repeat (hold) begin
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
        end
    endtask

    task automatic show_digit(input int k, input logic [3:0] nib, input logic dp, input int hold);
        logic [7:0] id;
        logic [7:0] pat;
        id  = 8'h01 << k;
        pat = code_tab[nib];
        pat[0] = ~dp;
        show(~id, pat, hold);
    endtask

    task automatic scan(input logic [31:0] nibs, input logic [7:0] dps, input int hold);
        for (int k = 0; k < 8; k++) show_digit(k, nibs[4*k +: 4], dps[k], hold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        seg_id = 8'hFF;
        seg_in = 8'hFF;
        model_reset();
        #1;
        check("rst_value",    value,             32'd0);
        check("rst_dp",       32'(dp_mask),      32'd0);
        check("rst_err",      32'(err_mask),     32'd0);
        check("rst_fv",       32'(frame_valid),  32'd0);
        check("rst_locked",   32'(locked),       32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_value", value, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        logic [31:0] rn;
        model_reset();
        do_reset();

        // Normal frame
        scan(32'h1234ABCD, 8'h10, 6);
        check("normal_value",  value,             32'h1234ABCD);
        check("normal_dp",     32'(dp_mask),      32'h10);
        check("normal_err",    32'(err_mask),     32'h0);
        check("normal_locked", 32'(locked),       32'd1);
        check("normal_pulses", 32'(obs_pulses),   32'd1);

        // Glitch rejection on digit 3
        p0 = obs_pulses;
        for (int k = 0; k < 3; k++) show_digit(k, 4'(k + 1), 1'b0, 6);
        show_digit(3, 4'h4, 1'b0, 4);
        for (int k = 4; k < 8; k++) show_digit(k, 4'(k + 1), 1'b0, 6);
        check("glitch_no_frame", 32'(obs_pulses), 32'(p0));
        show_digit(3, 4'h4, 1'b0, 5);
        check("glitch_frame",  32'(obs_pulses), 32'(p0 + 1));
        check("glitch_value",  value,           32'h87654321);

        // SYNC alignment
        do_reset();
        for (int k = 5; k < 8; k++) show_digit(k, 4'hE, 1'b1, 6);
        check("sync_unlocked", 32'(locked), 32'd0);
        p0 = obs_pulses;
        scan(32'h0F1E2D3C, 8'h00, 6);
        check("sync_one_frame", 32'(obs_pulses), 32'(p0 + 1));
        check("sync_value",     value,           32'h0F1E2D3C);
        check("sync_dp",        32'(dp_mask),    32'h00);

        // Errors and blank
        for (int k = 0; k < 8; k++) begin
            if (k == 2)      show(~(8'h04), 8'hFF, 6);
            else if (k == 6) show(~(8'h40), 8'h55, 6);
            else             show_digit(k, 4'(k + 2), 1'b0, 6);
        end
        check("err_mask_44", 32'(err_mask), 32'h44);
        check("err_value",   value,         32'h90765032);

        // Illegal selects mid-frame
        p0 = obs_pulses;
        for (int k = 0; k < 4; k++) show_digit(k, 4'hB, 1'b1, 6);
        show(8'hFC, 8'h03, 10);
        show(8'hFF, 8'h03, 10);
        check("illegal_no_frame", 32'(obs_pulses), 32'(p0));
        for (int k = 4; k < 8; k++) show_digit(k, 4'hC, 1'b0, 6);
        check("illegal_frame", 32'(obs_pulses), 32'(p0 + 1));
        check("illegal_value", value,           32'hCCCCBBBB);
        check("illegal_dp",    32'(dp_mask),    32'h0F);

        // Mid-frame reset
        for (int k = 0; k < 5; k++) show_digit(k, 4'hA, 1'b1, 6);
        do_reset();
        scan(32'h76543210, 8'h81, 6);
        check("mrst_value", value,          32'h76543210);
        check("mrst_dp",    32'(dp_mask),   32'h81);
        check("mrst_err",   32'(err_mask),  32'h00);

        // Randomized scanning
        for (int it = 0; it < 20; it++) begin
            for (int j = 0; j < 12; j++) begin
                int mode;
                mode = int'($urandom_range(9, 0));
                if (mode < 8)
                    show_digit(int'($urandom_range(7, 0)), 4'($urandom_range(15, 0)),
                               1'($urandom_range(1, 0)), int'($urandom_range(S + 4, S + 1)));
                else if (mode == 8)
                    show_digit(int'($urandom_range(7, 0)), 4'($urandom_range(15, 0)),
                               1'b0, int'($urandom_range(S, 1)));
                else
                    show(~(8'h01 << $urandom_range(7, 0)), 8'($urandom()),
                         int'($urandom_range(S + 3, S + 1)));
            end
            rn = $urandom();
            scan(rn, 8'($urandom()), int'($urandom_range(S + 3, S + 1)));
        end

        check("pulse_count", 32'(obs_pulses), 32'(exp_pulses));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the team's hex-to-seven-segment encoder. It monitors an 8-digit, time-multiplexed, active-low segment bus (digit select plus segment pattern), waits for each pattern to be stable, and decodes it back to a hex nibble. It assembles complete 8-digit frames and publishes a 32-bit value with per-digit decimal-point and error masks. It sits on the display bus as a loop-back checker and capture front-end for self-test.

## Interface
- STABLE_CYC, default 4: number of consecutive equal samples (after the change edge) required before a digit is accepted; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- seg_id  in  8  digit select, active low; bit k low selects digit k.
- seg_in  in  8  segment pattern, active low, bits [7:0] = a,b,c,d,e,f,g,dp.
- value  out  32  last published frame; digit k occupies value[4k+3:4k].
- dp_mask  out  8  bit k = 1 when digit k's dp was lit (seg_in[0] = 0).
- err_mask  out  8  bit k = 1 when digit k's pattern (bits [7:1]) matched no hex code.
- frame_valid  out  1  one-cycle pulse when value, dp_mask and err_mask update.
- locked  out  1  high once the first frame has been published.

## Operation
- **Input register.** {seg_id, seg_in} is registered every cycle into s_q.
- **Stability counter.**
  - Input differs from s_q: cnt <= 0.
  - Input equals s_q and cnt < STABLE_CYC: cnt increments.
  - Capture strobe fires when input equals s_q and cnt == STABLE_CYC-1. It fires exactly once per stable period; cnt then saturates at STABLE_CYC.
- **Capture qualification.** A capture is taken only when seg_id has exactly one zero bit. If seg_id is all ones or has several zeros, the strobe is dropped and nothing changes.
- **Decode.** Compare pattern bits [7:1] against the codes below (hex byte shown with dp bit = 1). Match gives nibble = the listed digit, err = 0. No match, including blank 0xFF, gives nibble = 0, err = 1. dp = ~seg_in[0].
  - 0:03, 1:9F, 2:25, 3:0D, 4:99, 5:49, 6:41, 7:1F
  - 8:01, 9:09, A:11, b:C1, C:63, d:85, E:61, F:71
- **Shadow registers.** Captures write shadow nibble/dp/err for digit k and set seen[k]. A repeat capture of the same digit overwrites it.
- **State machine.**
  - SYNC (reset state): captures of digits 1..7 are ignored. A capture of digit 0 writes shadow[0], sets seen = 8'h01, and moves to COLLECT.
  - COLLECT: accepts all digits. When the current capture makes seen == 8'hFF:
    - value, dp_mask and err_mask load from the shadow registers, with the completing capture merged in the same edge.
    - frame_valid pulses and locked is set.
    - seen is cleared and the state stays COLLECT; the next frame may start on any digit.
- **Reset.** Reset at any time, including mid-frame, returns to SYNC immediately and discards the partial frame.

## Timing
- Reset values:
  - value = 0, dp_mask = 0, err_mask = 0, frame_valid = 0, locked = 0.
  - cnt = 0, s_q = 16'hFFFF, seen = 0, state = SYNC.
- Let edge N be the first rising edge at which a new input pair is present. The pair must stay constant through edge N+STABLE_CYC; the capture happens at edge N+STABLE_CYC.
- With STABLE_CYC = 1, a pair held for 2 edges is captured.
- A change at any edge before N+STABLE_CYC restarts the count; no capture occurs.
- Completing capture at edge M: value, masks and frame_valid are visible in the cycle after edge M. frame_valid is low again after edge M+1 unless another frame completes at M+1 (not possible for STABLE_CYC ≥ 1 with 8 digits).
- Outputs are all registered; no combinational path from inputs to outputs.

## Test plan
- **Normal frame.** STABLE_CYC = 4; scan digits 0..7 showing D,C,B,A,4,3,2,1, each held 6 cycles, dp lit on digit 4 only.
  - Required: a single frame_valid pulse, value = 32'h1234ABCD, dp_mask = 8'h10, err_mask = 0, locked = 1.
- **Glitch rejection.** Hold digit 3 for only 4 edges (N..N+3).
  - Required: no capture; a frame containing that short pulse does not complete until digit 3 is re-shown for 5 edges.
- **SYNC alignment.** After reset, start the scan at digit 5.
  - Required: digits 5..7 are ignored; the first frame_valid follows the first full 0..7 sweep; locked stays 0 until then.
- **Errors and blank.** Digit 2 shows 0xFF and digit 6 shows 0x55.
  - Required: err_mask = 8'h44, nibbles 2 and 6 = 0, remaining digits decoded correctly.
- **Illegal select.** seg_id = 8'hFC held stable, and seg_id = 8'hFF held stable.
  - Required: no capture and no change to seen or outputs.
- **Mid-frame reset.** Assert rst after digits 0..4 are captured, then rescan 0..7 showing 8'h0-F values.
  - Required: all outputs 0 during reset, and the first pulse carries only post-reset data.
